alu_result_stage: RTL
=====================

// Module: alu_result_stage
// PURPOSE
//   Registered output stage directly downstream of the combinational ALU units (bit deposit,
//   shifts, adders). Captures each ALU result with its destination tag, derives zero and negative
//   flags, and presents them to writeback over a valid/ready handshake.
//   A 2-entry skid buffer fully decouples backpressure, so in_ready is a registered signal.
// PARAMETERS
//   DATA_W  32  result width in bits; equals the ALU operand width
//   TAG_W   5   destination-register tag width
// PORTS
//   clk         in   1       rising-edge clock
//   rst_n       in   1       synchronous active-low reset
//   flush       in   1       drop all buffered entries (pipeline redirect)
//   in_valid    in   1       ALU result valid
//   in_ready    out  1       stage can accept a result
//   in_result   in   DATA_W  ALU result (e.g. deposit output)
//   in_tag      in   TAG_W   destination tag
//   out_valid   out  1       head entry valid
//   out_ready   in   1       writeback accepts the head entry
//   out_result  out  DATA_W  head result
//   out_tag     out  TAG_W   head tag
//   out_zero    out  1       head result == 0
//   out_neg     out  1       head result[DATA_W-1]
//   out_parity  out  1       even parity of the head result (present only with ALU_RESULT_PARITY_EN)
// BEHAVIOUR
//   - Storage: 2 entries {result, tag, zero, neg}. Entry0 is the head and drives out_*. Entry1 is the skid.
//   - Count states: EMPTY (0), ONE (1), FULL (2). Count is held in a register.
//   - in_ready = (count != FULL), registered, so it does not depend combinationally on out_ready.
//   - Accept = in_valid & in_ready. Pop = out_valid & out_ready.
//   - EMPTY + accept -> ONE; the entry is loaded into entry0.
//   - ONE + accept, no pop -> FULL; the entry is loaded into entry1.
//   - ONE + pop, no accept -> EMPTY.
//   - ONE + accept + pop -> stays ONE; the new entry is loaded into entry0.
//   - FULL + pop -> ONE; entry1 moves to entry0. No accept is possible in FULL.
//   - Flags are computed from in_result at capture time and stored with the entry.
//   - out_* are driven straight from entry0 registers. There is no combinational path from in_* to out_*.
//   - Latency: a result accepted in cycle N is visible on out_* in cycle N+1.
//   - Order: results leave strictly in acceptance order. None are dropped or duplicated except on flush.
//   - Data stability: while out_valid & !out_ready, all out_* hold stable.
//   - flush: in the next cycle count = EMPTY and in_ready = 1. An accept in the flush cycle is discarded.
//     flush has priority over accept and pop.
//   - Reset (rst_n = 0 at a clk edge): count = EMPTY, out_valid = 0, in_ready = 1,
//     out_result = 0, out_tag = 0, out_zero = 1, out_neg = 0, out_parity = 0.
//     A reset taken mid-stream drops all buffered entries.
//   - out_zero and out_neg are meaningful only while out_valid = 1.
//     When the stage empties they hold the last entry0 contents.
// CONFIGURATION
//   ALU_RESULT_PARITY_EN defined:
//     - Each entry also stores ^in_result, computed at capture time.
//     - out_parity = stored bit of entry0; reset value 0.
//   ALU_RESULT_PARITY_EN undefined:
//     - No out_port, no parity storage.
//     - All other behaviour is identical.
// TESTING
//   - Reset: hold rst_n = 0 for 2 cycles -> out_valid = 0, in_ready = 1, out_zero = 1, out_result = 0.
//   - Single pass: in_result = 32'h8000_0000, tag = 3, out_ready = 1
//     -> next cycle out_valid = 1, result 32'h8000_0000, tag 3, neg = 1, zero = 0.
//   - Backpressure: out_ready = 0; push 32'h0 then 32'h5
//     -> in_ready = 0 after the 2nd accept; the head shows 0 with zero = 1.
//     Then raise out_ready -> 0 and 5 emerge in order on consecutive cycles.
//   - Streaming: in_valid = out_ready = 1 for 10 cycles with results 1..10
//     -> 10 outputs 1..10, one per cycle, in_ready never drops.
//   - Flush: FULL with tags 7 and 8; assert flush together with in_valid (tag 9)
//     -> next cycle out_valid = 0, in_ready = 1, tag 9 never appears.
//   - Parity (ALU_RESULT_PARITY_EN): result 32'h0000_0007 -> out_parity = 1;
//     result 32'h0000_0003 -> out_parity = 0.

Source files
------------

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered ALU result stage with a 2-entry skid buffer.
// Captures {result, tag} plus zero/neg flags and hands them to writeback
// over valid/ready; in_ready is registered so backpressure never ripples
// combinationally upstream.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush             drop all buffered entries
//   in_valid/in_ready ALU-side handshake
//   in_result, in_tag ALU result and destination tag
//   out_valid/ready   writeback-side handshake
//   out_result/tag    head entry contents
//   out_zero/neg      head flags (valid only while out_valid)
//   out_parity        head even parity (only with ALU_RESULT_PARITY_EN)
//
// Option macro: ALU_RESULT_PARITY_EN adds a stored parity bit per entry.

module alu_result_stage #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_zero,
    output logic              out_neg
`ifdef ALU_RESULT_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } cnt_t;

    cnt_t cnt_q, cnt_d;
    logic rdy_q;

    // entry0 = head, entry1 = skid
    logic [DATA_W-1:0] e0_res, e1_res;
    logic [TAG_W-1:0]  e0_tag, e1_tag;
    logic              e0_z, e1_z;
    logic              e0_n, e1_n;
`ifdef ALU_RESULT_PARITY_EN
    logic              e0_p, e1_p;
    logic              in_p;
`endif

    logic accept, pop;
    logic ld0_in, ld0_sk, ld1_in;
    logic in_z, in_n;

    assign accept = in_valid & rdy_q;
    assign pop    = out_valid & out_ready;
    assign in_z   = (in_result == '0);
    assign in_n   = in_result[DATA_W-1];
`ifdef ALU_RESULT_PARITY_EN
    assign in_p   = ^in_result;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        ld0_in = 1'b0;
        ld0_sk = 1'b0;
        ld1_in = 1'b0;
        if (flush) begin
            cnt_d = EMPTY;
        end else begin
            unique case (cnt_q)
                EMPTY: begin
                    if (accept) begin
                        cnt_d  = ONE;
                        ld0_in = 1'b1;
                    end
                end
                ONE: begin
                    unique case ({accept, pop})
                        2'b10: begin
                            cnt_d  = FULL;
                            ld1_in = 1'b1;
                        end
                        2'b01: cnt_d = EMPTY;
                        2'b11: ld0_in = 1'b1;
                        default: cnt_d = ONE;
                    endcase
                end
                FULL: begin
                    // rdy_q is low here, so no accept can coincide
                    if (pop) begin
                        cnt_d  = ONE;
                        ld0_sk = 1'b1;
                    end
                end
                default: cnt_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= EMPTY;
            rdy_q  <= 1'b1;
            e0_res <= '0;
            e0_tag <= '0;
            e0_z   <= 1'b1;
            e0_n   <= 1'b0;
            e1_res <= '0;
            e1_tag <= '0;
            e1_z   <= 1'b1;
            e1_n   <= 1'b0;
`ifdef ALU_RESULT_PARITY_EN
            e0_p   <= 1'b0;
            e1_p   <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d != FULL);
            if (ld0_in) begin
                e0_res <= in_result;
                e0_tag <= in_tag;
                e0_z   <= in_z;
                e0_n   <= in_n;
`ifdef ALU_RESULT_PARITY_EN
                e0_p   <= in_p;
`endif
            end else if (ld0_sk) begin
                e0_res <= e1_res;
                e0_tag <= e1_tag;
                e0_z   <= e1_z;
                e0_n   <= e1_n;
`ifdef ALU_RESULT_PARITY_EN
                e0_p   <= e1_p;
`endif
            end
            if (ld1_in) begin
                e1_res <= in_result;
                e1_tag <= in_tag;
                e1_z   <= in_z;
                e1_n   <= in_n;
`ifdef ALU_RESULT_PARITY_EN
                e1_p   <= in_p;
`endif
            end
        end
    end

    assign in_ready   = rdy_q;
    assign out_valid  = (cnt_q != EMPTY);
    assign out_result = e0_res;
    assign out_tag    = e0_tag;
    assign out_zero   = e0_z;
    assign out_neg    = e0_n;
`ifdef ALU_RESULT_PARITY_EN
    assign out_parity = e0_p;
`endif

endmodule
